// File: rtl/ram_mem_bridge.sv
// ram_mem_bridge: initiator side of the on-chip RAM port.
// Turns the PicoRV32 native valid/ready handshake into registered ce/wr/addr/d
// strobes for a 1-cycle-latency synchronous RAM, and answers accesses outside
// the RAM window with an error response plus a sticky error flag.
// Optional feature macro: RDATA_REG_EN (registers read data before mem_ready,
// adding one cycle of latency to in-window accesses).

module ram_mem_bridge #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  ram_ce,
    output logic [3:0]            ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_d,
    input  logic [31:0]           ram_q,
    output logic                  err_flag,
    input  logic                  err_clr
);

    // Bits above the word address select the window; the byte offset is ignored.
    localparam int WINDOW_SHIFT = ADDR_WIDTH + 2;

`ifdef RDATA_REG_EN
    typedef enum logic [2:0] {IDLE, ACCESS, RESP, ERR, RDREG} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACCESS, RESP, ERR} state_t;
`endif

    state_t      state;
    logic        in_window;
    logic        rd_op;
    logic        ready_reg;
    logic [31:0] rdata_reg;

    assign in_window = (mem_addr >> WINDOW_SHIFT) == (BASE_ADDR >> WINDOW_SHIFT);
    assign mem_ready = ready_reg;

`ifdef RDATA_REG_EN
    assign mem_rdata = rdata_reg;
`else
    // RAM data is already valid during RESP, so it is forwarded straight through.
    assign mem_rdata = (state == RESP && rd_op) ? ram_q : rdata_reg;
`endif

    // Request sequencing: accept in IDLE, strobe the RAM for one cycle, respond once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ready_reg <= 1'b0;
            rdata_reg <= 32'h0;
            ram_ce    <= 1'b0;
            ram_wr    <= 4'h0;
            ram_addr  <= '0;
            ram_d     <= 32'h0;
            err_flag  <= 1'b0;
            rd_op     <= 1'b0;
        end else begin
            if (err_clr) begin
                err_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    ram_ce    <= 1'b0;
                    ram_wr    <= 4'h0;
                    ready_reg <= 1'b0;
                    rdata_reg <= 32'h0;
                    if (mem_valid) begin
                        rd_op <= (mem_wstrb == 4'b0000);
                        if (in_window) begin
                            state    <= ACCESS;
                            ram_ce   <= 1'b1;
                            ram_wr   <= mem_wstrb;
                            ram_addr <= mem_addr[ADDR_WIDTH+1:2];
                            ram_d    <= mem_wdata;
                        end else begin
                            state     <= ERR;
                            ready_reg <= 1'b1;
                            rdata_reg <= (mem_wstrb == 4'b0000) ? ERR_RDATA : 32'h0;
                            err_flag  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    ram_ce <= 1'b0;
                    ram_wr <= 4'h0;
                    state  <= RESP;
`ifndef RDATA_REG_EN
                    ready_reg <= 1'b1;
`endif
                end
                RESP: begin
`ifdef RDATA_REG_EN
                    ready_reg <= 1'b1;
                    rdata_reg <= rd_op ? ram_q : 32'h0;
                    state     <= RDREG;
`else
                    ready_reg <= 1'b0;
                    state     <= IDLE;
`endif
                end
`ifdef RDATA_REG_EN
                RDREG: begin
                    ready_reg <= 1'b0;
                    rdata_reg <= 32'h0;
                    state     <= IDLE;
                end
`endif
                ERR: begin
                    ready_reg <= 1'b0;
                    rdata_reg <= 32'h0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_mem_bridge.sv
// tb_ram_mem_bridge: self-checking bench for ram_mem_bridge.
// Provides a synchronous byte-writable RAM behind the bridge and compares the
// CPU-side responses against a word-level memory model built from the
// address-window and byte-strobe rules.

module tb_ram_mem_bridge;

    localparam int          AW        = 16;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
`ifdef RDATA_REG_EN
    localparam int          IN_LATENCY = 3;
`else
    localparam int          IN_LATENCY = 2;
`endif

    logic          clk;
    logic          resetn;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          ram_ce;
    logic [3:0]    ram_wr;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_d;
    logic [31:0]   ram_q;
    logic          err_flag;
    logic          err_clr;

    int check_count = 0;
    int error_count = 0;

    logic [31:0] ram_array [0:(1<<AW)-1];
    logic [31:0] ref_mem [int];

    ram_mem_bridge #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .ERR_RDATA (ERR_DATA)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ram_ce   (ram_ce),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q),
        .err_flag (err_flag),
        .err_clr  (err_clr)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM: data for a chip-enabled cycle appears the next cycle
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_array[i] = 32'h0;
        ram_q = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_ce) begin
            ram_q <= ram_array[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_wr[b]) ram_array[ram_addr][b*8 +: 8] <= ram_d[b*8 +: 8];
            end
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    // One complete CPU transaction, checked cycle by cycle against the model
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] rdata_seen);
        logic [31:0] exp_rdata;
        logic [31:0] word;
        logic [AW-1:0] widx;
        int cycles;
        widx = addr[AW+1:2];
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        step();
        cycles = 1;
        if (in_win(addr)) begin
            checkOutput("ram_ce_at_T1", ram_ce, 1);
            checkOutput("ram_wr_at_T1", ram_wr, wstrb);
            checkOutput("ram_addr_at_T1", ram_addr, widx);
            checkOutput("ram_d_at_T1", ram_d, wdata);
            checkOutput("ready_low_at_T1", mem_ready, 0);
            word = ref_mem.exists(int'(widx)) ? ref_mem[int'(widx)] : 32'h0;
            if (wstrb == 4'h0) begin
                exp_rdata = word;
            end else begin
                exp_rdata = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
                end
                ref_mem[int'(widx)] = word;
            end
            while (!mem_ready && cycles < 8) begin
                step();
                cycles++;
            end
            checkOutput("in_window_latency", cycles, IN_LATENCY);
        end else begin
            exp_rdata = (wstrb == 4'h0) ? ERR_DATA : 32'h0;
            checkOutput("err_ready_at_T1", mem_ready, 1);
            checkOutput("err_flag_set", err_flag, 1);
        end
        checkOutput("ce_low_with_ready", ram_ce, 0);
        rdata_seen = mem_rdata;
        checkOutput("mem_rdata", mem_rdata, exp_rdata);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        step();
        checkOutput("ready_single_pulse", mem_ready, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [3:0]  s;
        int sel;

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        err_clr   = 1'b0;
        step();
        step();
        checkOutput("rst_mem_ready", mem_ready, 0);
        checkOutput("rst_mem_rdata", mem_rdata, 0);
        checkOutput("rst_ram_ce", ram_ce, 0);
        checkOutput("rst_ram_wr", ram_wr, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_d", ram_d, 0);
        checkOutput("rst_err_flag", err_flag, 0);
        resetn = 1'b1;
        step();

        // Directed: full write, read back, partial write merge
        applyStimulus(32'h0000_0010, 32'h1234_5678, 4'hF, r);
        applyStimulus(32'h0000_0010, 32'h0, 4'h0, r);
        checkOutput("t2_readback", r, 32'h1234_5678);
        applyStimulus(32'h0000_0010, 32'hAABB_CCDD, 4'b0100, r);
        applyStimulus(32'h0000_0010, 32'h0, 4'h0, r);
        checkOutput("t3_partial_merge", r, 32'h12BB_5678);

        // Directed: out-of-window read, sticky flag, clear
        applyStimulus(32'h0004_0000, 32'h0, 4'h0, r);
        checkOutput("t4_err_rdata", r, 32'hDEAD_BEEF);
        checkOutput("t4_flag_sticky", err_flag, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("t4_flag_cleared", err_flag, 0);

        // Directed: set wins over a simultaneous clear; out-of-window write returns 0
        err_clr = 1'b1;
        applyStimulus(32'h8000_0004, 32'h5555_AAAA, 4'hF, r);
        err_clr = 1'b0;
        checkOutput("set_wins_rdata", r, 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Directed: last word of the window
        applyStimulus(32'h0003_FFFC, 32'hCAFE_F00D, 4'hF, r);
        applyStimulus(32'h0003_FFFC, 32'h0, 4'h0, r);
        checkOutput("t5_top_word", r, 32'hCAFE_F00D);

        // Directed: reset while the RAM access is in flight
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0020;
        mem_wstrb = 4'h0;
        step();
        checkOutput("t6_ce_in_access", ram_ce, 1);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        step();
        checkOutput("t6_ready", mem_ready, 0);
        checkOutput("t6_rdata", mem_rdata, 0);
        checkOutput("t6_ce", ram_ce, 0);
        checkOutput("t6_wr", ram_wr, 0);
        checkOutput("t6_addr", ram_addr, 0);
        checkOutput("t6_d", ram_d, 0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t6_no_response", mem_ready, 0);
        end
        applyStimulus(32'h0000_0020, 32'h0BAD_CAFE, 4'hF, r);
        applyStimulus(32'h0000_0020, 32'h0, 4'h0, r);
        checkOutput("t6_recover", r, 32'h0BAD_CAFE);

        // Randomized traffic against the word-level model
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                a = $urandom;
                if (in_win(a)) a = a | 32'h8000_0000;
            end else if (sel == 2) begin
                a = 32'h0003_FFFC | 32'($urandom_range(0, 3));
            end else begin
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            applyStimulus(a, $urandom, s, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
